traffic_seq_monitor: RTL

- Receive-side checker for the UK traffic-light lamp outputs (red, amber, green) produced by the traffic-light sequencer.
- Samples the three lamp lines every clock and decodes them into a phase.
- Checks every observed step against the legal sequence RED -> RED_AMBER -> GREEN -> AMBER -> RED.
- Flags violations, counts errors and completed cycles; sits alongside the sequencer in the board-level checker / test harness.

---
 rtl/traffic_seq_monitor_pkg.sv | 50 +++++
 rtl/traffic_seq_monitor_sat_counter.sv | 22 ++
 rtl/traffic_seq_monitor.sv | 132 +++++++++++++
 3 files changed

// File: rtl/traffic_seq_monitor_pkg.sv
// traffic_pkg: shared encodings for the UK traffic-light sequencer and its
// receive-side monitor.
//   - PH_*   : 2-bit phase numbering (RED, RED_AMBER, GREEN, AMBER)
//   - PAT_*  : lamp patterns, bit order {red, amber, green}
//   - ERR_*  : monitor error-cause codes
// Helpers classify a raw lamp pattern and map it to its phase.
package traffic_pkg;

  localparam logic [1:0] PH_RED       = 2'd0;
  localparam logic [1:0] PH_RED_AMBER = 2'd1;
  localparam logic [1:0] PH_GREEN     = 2'd2;
  localparam logic [1:0] PH_AMBER     = 2'd3;

  localparam logic [2:0] PAT_RED       = 3'b100;
  localparam logic [2:0] PAT_RED_AMBER = 3'b110;
  localparam logic [2:0] PAT_GREEN     = 3'b001;
  localparam logic [2:0] PAT_AMBER     = 3'b010;

  localparam logic [1:0] ERR_NONE    = 2'b00;
  localparam logic [1:0] ERR_PATTERN = 2'b01;
  localparam logic [1:0] ERR_TRANS   = 2'b10;
  localparam logic [1:0] ERR_STUCK   = 2'b11;

  typedef enum logic {
    ST_UNLOCKED = 1'b0,
    ST_LOCKED   = 1'b1
  } mon_state_e;

  // One step's verdict: whether it errors and why.
  typedef struct packed {
    logic       err;
    logic [1:0] code;
  } chk_res_t;

  function automatic logic pat_legal(input logic [2:0] pat);
    return (pat == PAT_RED) || (pat == PAT_RED_AMBER) ||
           (pat == PAT_GREEN) || (pat == PAT_AMBER);
  endfunction

  // Only meaningful for legal patterns; illegal ones map to PH_RED.
  function automatic logic [1:0] pat2ph(input logic [2:0] pat);
    case (pat)
      PAT_RED_AMBER: return PH_RED_AMBER;
      PAT_GREEN:     return PH_GREEN;
      PAT_AMBER:     return PH_AMBER;
      default:       return PH_RED;
    endcase
  endfunction

endpackage

// File: rtl/traffic_seq_monitor_sat_counter.sv
// sat_counter: W-bit up counter that sticks at all-ones.
//   clk   : rising-edge clock
//   rst   : synchronous active-high clear
//   inc   : count one on this edge (ignored once saturated)
//   count : current value
module sat_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  output logic [W-1:0] count
);

  always_ff @(posedge clk) begin
    if (rst)
      count <= '0;
    else if (inc && (count != {W{1'b1}}))
      count <= count + W'(1);
  end

endmodule

// File: rtl/traffic_seq_monitor.sv
// traffic_seq_monitor: receive-side checker for the red/amber/green lamp lines.
// Samples {red,amber,green} every clock, locks onto the first legal pattern and
// then checks each step against RED -> RED_AMBER -> GREEN -> AMBER -> RED.
//   clk, rst     : clock, synchronous active-high reset
//   red/amber/green : lamp lines
//   locked       : synchronised to a legal phase
//   phase        : decoded phase (PH_* encoding)
//   err          : one-cycle error pulse
//   err_code     : cause of the most recent error (held)
//   err_count    : saturating error count
//   cycle_count  : saturating count of AMBER->RED steps while locked
// All outputs are registered: inputs at edge N show after edge N.
// Optional build macro TRAFFIC_MON_STUCK_CHECK_EN adds a dwell counter that
// flags a pattern held for MAX_DWELL cycles while locked (err_code 11).
module traffic_seq_monitor
  import traffic_pkg::*;
#(
  parameter int CNT_W     = 8,
  parameter int MAX_DWELL = 16,
  parameter int DWELL_W   = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             red,
  input  logic             amber,
  input  logic             green,
  output logic             locked,
  output logic [1:0]       phase,
  output logic             err,
  output logic [1:0]       err_code,
  output logic [CNT_W-1:0] err_count,
  output logic [CNT_W-1:0] cycle_count
);

  if (MAX_DWELL < 2 || MAX_DWELL > (1 << DWELL_W) - 1) begin : g_bad_cfg
    $error("traffic_seq_monitor: MAX_DWELL out of range for DWELL_W");
  end

  mon_state_e state;
  logic [2:0] pat, prev_pat;
  logic       legal, same, cyc_inc;
  logic [1:0] pat_ph, ph_succ;
  chk_res_t   res;

  assign pat     = {red, amber, green};
  assign legal   = pat_legal(pat);
  assign pat_ph  = pat2ph(pat);
  assign ph_succ = phase + 2'd1;
  assign same    = (pat == prev_pat);
  assign locked  = (state == ST_LOCKED);

`ifdef TRAFFIC_MON_STUCK_CHECK_EN
  logic [DWELL_W-1:0] dwell;
  logic               stuck_hit;

  assign stuck_hit = (state == ST_LOCKED) && legal && same &&
                     (dwell == DWELL_W'(MAX_DWELL - 1));

  // Cleared on any change, while unlocked (so also on lock), and on a hit,
  // which makes the stuck error repeat every MAX_DWELL cycles.
  always_ff @(posedge clk) begin
    if (rst || (state != ST_LOCKED) || !same || stuck_hit)
      dwell <= '0;
    else
      dwell <= dwell + DWELL_W'(1);
  end
`else
  logic stuck_hit;
  assign stuck_hit = 1'b0;
`endif

  // Verdict for this step; priority is pattern > transition > stuck.
  always_comb begin
    res     = '{err: 1'b0, code: ERR_NONE};
    cyc_inc = 1'b0;
    if (state == ST_LOCKED) begin
      if (!legal)
        res = '{err: 1'b1, code: ERR_PATTERN};
      else if (!same) begin
        if (pat_ph == ph_succ)
          cyc_inc = (phase == PH_AMBER);
        else
          res = '{err: 1'b1, code: ERR_TRANS};
      end else if (stuck_hit)
        res = '{err: 1'b1, code: ERR_STUCK};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_UNLOCKED;
      phase    <= PH_RED;
      err      <= 1'b0;
      err_code <= ERR_NONE;
      prev_pat <= 3'b000;
    end else begin
      prev_pat <= pat;
      err      <= res.err;
      if (res.err)
        err_code <= res.code;
      case (state)
        // Illegal patterns before lock are silently ignored.
        ST_UNLOCKED: if (legal) begin
          state <= ST_LOCKED;
          phase <= pat_ph;
        end
        // Illegal pattern drops lock but keeps the last phase; any legal
        // pattern (successor or resync) becomes the new phase.
        ST_LOCKED: if (!legal)
          state <= ST_UNLOCKED;
        else
          phase <= pat_ph;
        default: state <= ST_UNLOCKED;
      endcase
    end
  end

  sat_counter #(.W(CNT_W)) u_err_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (res.err),
    .count (err_count)
  );

  sat_counter #(.W(CNT_W)) u_cyc_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (cyc_inc),
    .count (cycle_count)
  );

endmodule
